// File: rtl/hsv2rgb_pkg.sv
// Shared types and constants for the HSV->RGB converter.
package hsv2rgb_pkg;

    localparam int unsigned BITWIDTH = 8;
    localparam int unsigned MAX_VAL  = (1 << BITWIDTH) - 1;
    localparam int unsigned LATENCY  = 4;
    localparam int unsigned PROD_W   = 2 * BITWIDTH;
    localparam int unsigned HX6_W    = BITWIDTH + 3;
    localparam int unsigned COUNT_W  = 16;

    typedef logic [BITWIDTH-1:0] channel_t;
    typedef logic [PROD_W-1:0]   prod_t;

    localparam channel_t CH_MAX = channel_t'(MAX_VAL);

    typedef enum logic [2:0] {
        SEC0 = 3'd0,
        SEC1 = 3'd1,
        SEC2 = 3'd2,
        SEC3 = 3'd3,
        SEC4 = 3'd4,
        SEC5 = 3'd5
    } sector_t;

    typedef struct packed {
        channel_t r;
        channel_t g;
        channel_t b;
    } rgb_t;

endpackage

// File: rtl/div_by_max.sv
// Combinational floor(x / M), M = 2^BITWIDTH-1; exact for x <= M*M.
module div_by_max
    import hsv2rgb_pkg::*;
(
    input  prod_t    x,
    output channel_t y_c
);

    prod_t sum_c;

    // Shift-add replacement for division by 2^N-1; cannot overflow for x <= M*M.
    assign sum_c = x + prod_t'(x >> BITWIDTH) + prod_t'(1);
    assign y_c   = channel_t'(sum_c >> BITWIDTH);

endmodule

// File: rtl/hsv2rgb.sv
// Pipelined HSV->RGB converter, fixed latency, no backpressure.
// Optional pixel counter enabled by defining HSV2RGB_COUNT_EN.
module hsv2rgb
    import hsv2rgb_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                hsv_inputs_valid,
    input  logic [BITWIDTH-1:0] h,
    input  logic [BITWIDTH-1:0] s,
    input  logic [BITWIDTH-1:0] v,
    output logic [BITWIDTH-1:0] r,
    output logic [BITWIDTH-1:0] g,
    output logic [BITWIDTH-1:0] b,
    output logic                rgb_valid
`ifdef HSV2RGB_COUNT_EN
    ,
    output logic [COUNT_W-1:0]  pixel_count
`endif
);

    logic [LATENCY-1:0] vld_q;

    channel_t h0_q, s0_q, v0_q;

    logic [HX6_W-1:0] hx6_c;
    sector_t          sec1_q;
    channel_t         f1_q, s1_q, v1_q;

    prod_t    sf_prod_c, sfi_prod_c;
    channel_t sf_div_c, sfi_div_c;
    sector_t  sec2_q;
    channel_t v2_q, ps2_q, qs2_q, ts2_q;

    prod_t    p_prod_c, q_prod_c, t_prod_c;
    channel_t p_div_c, q_div_c, t_div_c;
    sector_t  sec3_q;
    channel_t v3_q, p3_q, q3_q, t3_q;

    rgb_t mux_c;

    // Stage 1: hue scaled to six sectors plus fractional position within the sector.
    assign hx6_c = HX6_W'(h0_q) * HX6_W'(3'd6);

    // Stage 2: saturation terms.
    assign sf_prod_c  = prod_t'(s1_q) * prod_t'(f1_q);
    assign sfi_prod_c = prod_t'(s1_q) * prod_t'(CH_MAX - f1_q);

    div_by_max u_div_qs (.x(sf_prod_c),  .y_c(sf_div_c));
    div_by_max u_div_ts (.x(sfi_prod_c), .y_c(sfi_div_c));

    // Stage 3: scale saturation terms by value.
    assign p_prod_c = prod_t'(v2_q) * prod_t'(ps2_q);
    assign q_prod_c = prod_t'(v2_q) * prod_t'(qs2_q);
    assign t_prod_c = prod_t'(v2_q) * prod_t'(ts2_q);

    div_by_max u_div_p (.x(p_prod_c), .y_c(p_div_c));
    div_by_max u_div_q (.x(q_prod_c), .y_c(q_div_c));
    div_by_max u_div_t (.x(t_prod_c), .y_c(t_div_c));

    // Stage 4: channel routing by sector.
    always_comb begin
        mux_c = '{r: v3_q, g: t3_q, b: p3_q};
        case (sec3_q)
            SEC0:    mux_c = '{r: v3_q, g: t3_q, b: p3_q};
            SEC1:    mux_c = '{r: q3_q, g: v3_q, b: p3_q};
            SEC2:    mux_c = '{r: p3_q, g: v3_q, b: t3_q};
            SEC3:    mux_c = '{r: p3_q, g: q3_q, b: v3_q};
            SEC4:    mux_c = '{r: t3_q, g: p3_q, b: v3_q};
            SEC5:    mux_c = '{r: v3_q, g: p3_q, b: q3_q};
            default: mux_c = '{r: v3_q, g: t3_q, b: p3_q};
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_q     <= '0;
            h0_q      <= '0;
            s0_q      <= '0;
            v0_q      <= '0;
            sec1_q    <= SEC0;
            f1_q      <= '0;
            s1_q      <= '0;
            v1_q      <= '0;
            sec2_q    <= SEC0;
            v2_q      <= '0;
            ps2_q     <= '0;
            qs2_q     <= '0;
            ts2_q     <= '0;
            sec3_q    <= SEC0;
            v3_q      <= '0;
            p3_q      <= '0;
            q3_q      <= '0;
            t3_q      <= '0;
            r         <= '0;
            g         <= '0;
            b         <= '0;
            rgb_valid <= 1'b0;
        end else begin
            vld_q  <= {vld_q[LATENCY-2:0], hsv_inputs_valid};
            h0_q   <= h;
            s0_q   <= s;
            v0_q   <= v;
            sec1_q <= sector_t'(hx6_c[HX6_W-1:BITWIDTH]);
            f1_q   <= hx6_c[BITWIDTH-1:0];
            s1_q   <= s0_q;
            v1_q   <= v0_q;
            sec2_q <= sec1_q;
            v2_q   <= v1_q;
            ps2_q  <= CH_MAX - s1_q;
            qs2_q  <= CH_MAX - sf_div_c;
            ts2_q  <= CH_MAX - sfi_div_c;
            sec3_q <= sec2_q;
            v3_q   <= v2_q;
            p3_q   <= p_div_c;
            q3_q   <= q_div_c;
            t3_q   <= t_div_c;
            // Outputs hold their last valid pixel through gaps.
            if (vld_q[LATENCY-1]) begin
                r <= mux_c.r;
                g <= mux_c.g;
                b <= mux_c.b;
            end
            rgb_valid <= vld_q[LATENCY-1];
        end
    end

`ifdef HSV2RGB_COUNT_EN
    // Saturating count of delivered pixels.
    always_ff @(posedge clock) begin
        if (reset) begin
            pixel_count <= '0;
        end else if (rgb_valid && (pixel_count != {COUNT_W{1'b1}})) begin
            pixel_count <= pixel_count + COUNT_W'(1);
        end
    end
`endif

endmodule
